div64_ctrl: RTL and testbench

- Sequencing controller for the 64-bit radix-4 SRT divider: request/response handshake, operand conditioning, special-case detection, normalization/iteration-count computation, iteration sequencing, capture of post-processed quotient/remainder, and final sign fix-up.
- Sits between the execute-stage issue logic and the iteration datapath plus post-processing stage.
- The post-processing stage takes iter_val/odd_leading_zero from this block and returns unsigned q/rem.

---
 rtl/div64_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_div64_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div64_ctrl.sv
// Sequencing controller for the 64-bit radix-4 SRT divider; DIV_RESULT_CACHE_EN adds a one-entry result cache.
// Latency: resp_valid iter_val+3 cycles after accept on the normal path, 1 cycle for special cases and cache hits.
// Backpressure: result held in DONE until resp_ready; req_ready only while IDLE and not flushing.
module div64_ctrl #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_dividend,
    input  logic [DATA_W-1:0] req_divisor,
    input  logic              req_signed,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_q,
    output logic [DATA_W-1:0] resp_rem,
    output logic              dp_load,
    output logic              dp_iter_en,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    output logic [CNT_W-1:0]  dp_a_lz,
    output logic [CNT_W-1:0]  dp_b_lz,
    output logic [CNT_W-1:0]  iter_val,
    output logic              odd_leading_zero,
    input  logic [DATA_W-1:0] pp_q,
    input  logic [DATA_W-1:0] pp_rem
);

    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q;
    logic               sign_r;

    logic               accept;
    logic [DATA_W-1:0]  abs_a;
    logic [DATA_W-1:0]  abs_b;
    logic               is_div0;
    logic               is_ovf;
    logic               is_small;
    logic [CNT_W-1:0]   lz_diff;
    logic [DATA_W-1:0]  q_fix;
    logic [DATA_W-1:0]  rem_fix;
    logic               cache_hit;
    logic [DATA_W-1:0]  hit_q;
    logic [DATA_W-1:0]  hit_rem;

    function automatic logic [CNT_W-1:0] lzc(input logic [DATA_W-1:0] v);
        lzc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (v[i]) lzc = CNT_W'(DATA_W - 1 - i);
        end
    endfunction

    assign req_ready = (state == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign abs_a     = (req_signed & req_dividend[DATA_W-1]) ? -req_dividend : req_dividend;
    assign abs_b     = (req_signed & req_divisor[DATA_W-1])  ? -req_divisor  : req_divisor;
    assign is_div0   = (req_divisor == '0);
    assign is_ovf    = req_signed && (req_dividend == {1'b1, {(DATA_W-1){1'b0}}}) && (req_divisor == '1);
    assign is_small  = (abs_a < abs_b);
    // Normal path guarantees |a| >= |b|, so the divisor has at least as many leading zeros.
    assign lz_diff   = dp_b_lz - dp_a_lz;
    assign q_fix     = sign_q ? -pp_q   : pp_q;
    assign rem_fix   = sign_r ? -pp_rem : pp_rem;

`ifdef DIV_RESULT_CACHE_EN
    logic              c_vld;
    logic              c_s;
    logic [DATA_W-1:0] c_a;
    logic [DATA_W-1:0] c_b;
    logic [DATA_W-1:0] c_q;
    logic [DATA_W-1:0] c_rem;
    logic              cur_s;
    logic [DATA_W-1:0] cur_a;
    logic [DATA_W-1:0] cur_b;

    assign cache_hit = c_vld && (c_a == req_dividend) && (c_b == req_divisor) && (c_s == req_signed);
    assign hit_q     = c_q;
    assign hit_rem   = c_rem;

    // Raw operands are kept so a killed operation never lands in the cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld <= 1'b0;
            c_s   <= 1'b0;
            c_a   <= '0;
            c_b   <= '0;
            c_q   <= '0;
            c_rem <= '0;
            cur_s <= 1'b0;
            cur_a <= '0;
            cur_b <= '0;
        end else begin
            if (accept) begin
                cur_a <= req_dividend;
                cur_b <= req_divisor;
                cur_s <= req_signed;
            end
            if (state == POST && !flush) begin
                c_vld <= 1'b1;
                c_a   <= cur_a;
                c_b   <= cur_b;
                c_s   <= cur_s;
                c_q   <= q_fix;
                c_rem <= rem_fix;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_q     = '0;
    assign hit_rem   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            sign_q           <= 1'b0;
            sign_r           <= 1'b0;
            resp_valid       <= 1'b0;
            resp_q           <= '0;
            resp_rem         <= '0;
            dp_load          <= 1'b0;
            dp_iter_en       <= 1'b0;
            dp_a             <= '0;
            dp_b             <= '0;
            dp_a_lz          <= '0;
            dp_b_lz          <= '0;
            iter_val         <= '0;
            odd_leading_zero <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            dp_load    <= 1'b0;
            dp_iter_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_a   <= abs_a;
                        dp_b   <= abs_b;
                        sign_q <= req_signed & (req_dividend[DATA_W-1] ^ req_divisor[DATA_W-1]);
                        sign_r <= req_signed & req_dividend[DATA_W-1];
                        if (is_div0) begin
                            resp_q     <= '1;
                            resp_rem   <= req_dividend;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else if (is_ovf) begin
                            resp_q     <= req_dividend;
                            resp_rem   <= '0;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else if (is_small) begin
                            resp_q     <= '0;
                            resp_rem   <= req_dividend;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else if (cache_hit) begin
                            resp_q     <= hit_q;
                            resp_rem   <= hit_rem;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dp_a_lz <= lzc(abs_a);
                            dp_b_lz <= lzc(abs_b);
                            dp_load <= 1'b1;
                            state   <= PRE;
                        end
                    end
                end
                PRE: begin
                    iter_val         <= (lz_diff >> 1) + CNT_W'(1);
                    odd_leading_zero <= lz_diff[0];
                    cnt              <= (lz_diff >> 1) + CNT_W'(1);
                    dp_load          <= 1'b0;
                    dp_iter_en       <= 1'b1;
                    state            <= ITER;
                end
                ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        dp_iter_en <= 1'b0;
                        state      <= POST;
                    end
                end
                POST: begin
                    resp_q     <= q_fix;
                    resp_rem   <= rem_fix;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div64_ctrl.sv
// Scoreboard bench for div64_ctrl: a behavioural divider model supplies expected results and the post-processing inputs.
module tb_div64_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_dividend = '0;
    logic [63:0] req_divisor = '0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_q;
    logic [63:0] resp_rem;
    logic        dp_load;
    logic        dp_iter_en;
    logic [63:0] dp_a;
    logic [63:0] dp_b;
    logic [5:0]  dp_a_lz;
    logic [5:0]  dp_b_lz;
    logic [5:0]  iter_val;
    logic        odd_leading_zero;
    logic [63:0] pp_q = '0;
    logic [63:0] pp_rem = '0;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] rem;
    } res_t;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    logic        c_vld = 1'b0;
    logic [63:0] c_a = '0;
    logic [63:0] c_b = '0;
    logic        c_s = 1'b0;

    always #5 clk = ~clk;

    div64_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_q(resp_q), .resp_rem(resp_rem),
        .dp_load(dp_load), .dp_iter_en(dp_iter_en),
        .dp_a(dp_a), .dp_b(dp_b), .dp_a_lz(dp_a_lz), .dp_b_lz(dp_b_lz),
        .iter_val(iter_val), .odd_leading_zero(odd_leading_zero),
        .pp_q(pp_q), .pp_rem(pp_rem)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mag(input logic [63:0] v, input logic s);
        return (s && v[63]) ? -v : v;
    endfunction

    function automatic logic [5:0] lead_zeros(input logic [63:0] v);
        int n = 64;
        while (v != 0) begin
            v = v >> 1;
            n--;
        end
        return 6'(n);
    endfunction

    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output res_t r, output logic special);
        logic signed [63:0] sa;
        logic signed [63:0] sd;
        sa = a;
        sd = b;
        special = 1'b1;
        if (b == 0) begin
            r.q = '1; r.rem = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            r.q = a; r.rem = '0;
        end else if (mag(a, s) < mag(b, s)) begin
            r.q = '0; r.rem = a;
        end else begin
            special = 1'b0;
            if (s) begin
                r.q = sa / sd; r.rem = sa % sd;
            end else begin
                r.q = a / b; r.rem = a % b;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input int hold);
        res_t        r;
        logic        special;
        logic        hit;
        logic        overlap;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [5:0]  alz;
        logic [5:0]  blz;
        int          lat;
        int          loads;
        int          iters;
        int          exp_iter;
        int          exp_lat;
        model(a, b, s, r, special);
        ua  = mag(a, s);
        ub  = mag(b, s);
        alz = lead_zeros(ua);
        blz = lead_zeros(ub);
        hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        hit = !special && c_vld && c_a == a && c_b == b && c_s == s;
`endif
        exp_iter = (special || hit) ? 0 : ((int'(blz) - int'(alz)) >> 1) + 1;
        exp_lat  = (special || hit) ? 1 : exp_iter + 3;

        @(negedge clk);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_signed   = s;
        pp_q   = (ub != 0) ? ua / ub : '0;
        pp_rem = (ub != 0) ? ua % ub : '0;
        exp_q.push_back(r);
        lat = 0; loads = 0; iters = 0; overlap = 1'b0;
        @(posedge clk);
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (dp_load) loads++;
            if (dp_iter_en) iters++;
            overlap |= dp_load & dp_iter_en;
        end while (!resp_valid && lat < 100);

        check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        if (!resp_valid) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " dp_load cycles"}, 64'(loads), 64'((special || hit) ? 0 : 1));
        check({tag, " dp_iter_en cycles"}, 64'(iters), 64'(exp_iter));
        check({tag, " load/iter overlap"}, 64'(overlap), 64'd0);
        if (!special && !hit) begin
            check({tag, " dp_a"}, dp_a, ua);
            check({tag, " dp_b"}, dp_b, ub);
            check({tag, " dp_a_lz"}, 64'(dp_a_lz), 64'(alz));
            check({tag, " dp_b_lz"}, 64'(dp_b_lz), 64'(blz));
            check({tag, " iter_val"}, 64'(iter_val), 64'(exp_iter));
            check({tag, " odd_lz"}, 64'(odd_leading_zero), 64'((blz - alz) & 6'd1));
        end
        for (int i = 0; i < hold; i++) begin
            check({tag, " held q"}, resp_q, exp_q[0].q);
            check({tag, " held rem"}, resp_rem, exp_q[0].rem);
            check({tag, " held valid"}, 64'(resp_valid), 64'd1);
            check({tag, " held req_ready"}, 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        check({tag, " q"}, resp_q, exp_q[0].q);
        check({tag, " rem"}, resp_rem, exp_q[0].rem);
        void'(exp_q.pop_front());
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " idle resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, " idle req_ready"}, 64'(req_ready), 64'd1);
        if (!special) begin
            c_vld = 1'b1; c_a = a; c_b = b; c_s = s;
        end
    endtask

    initial begin
        logic        seen;
        logic        s;
        logic [63:0] a;
        logic [63:0] b;

        #2 rst_n = 1'b0;
        req_dividend = 64'h1234;
        pp_q = 64'hdead;
        repeat (2) @(negedge clk);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_q", resp_q, 64'd0);
        check("rst resp_rem", resp_rem, 64'd0);
        check("rst dp_a", dp_a, 64'd0);
        check("rst dp_b", dp_b, 64'd0);
        check("rst lz", 64'({dp_a_lz, dp_b_lz}), 64'd0);
        check("rst iter_val", 64'({iter_val, odd_leading_zero}), 64'd0);
        check("rst dp ctl", 64'({dp_load, dp_iter_en}), 64'd0);
        rst_n = 1'b1;

        do_op("u100/7", 64'd100, 64'd7, 1'b0, 0);
        do_op("u100/7 again", 64'd100, 64'd7, 1'b0, 0);
        do_op("s-7/2", -64'sd7, 64'd2, 1'b1, 0);
        do_op("div0", 64'd5, 64'd0, 1'b0, 0);
        do_op("s ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 0);
        do_op("small", 64'd3, 64'd10, 1'b0, 0);
        do_op("backpressure", 64'd200, 64'd3, 1'b0, 4);

        // 1000/3 runs five iterations, so the third negedge after accept is the second ITER cycle.
        @(negedge clk);
        req_valid = 1'b1; req_dividend = 64'd1000; req_divisor = 64'd3; req_signed = 1'b0;
        pp_q = 64'd333; pp_rem = 64'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("flush pre iter_en", 64'(dp_iter_en), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush resp_valid", 64'(resp_valid), 64'd0);
        check("flush req_ready", 64'(req_ready), 64'd1);
        check("flush dp_iter_en", 64'(dp_iter_en), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= resp_valid | dp_iter_en;
        end
        check("flush no response", 64'(seen), 64'd0);

        do_op("u9/3", 64'd9, 64'd3, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            s = i[0];
            a = {$urandom, $urandom};
            b = 64'($urandom_range(1, 5000));
            if (s && $urandom_range(0, 1) == 1) b = -b;
            if (i % 4 == 3) a = a >> $urandom_range(40, 63);
            do_op("rand", a, b, s, i % 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
